// File: rtl/button_conditioner.sv
// Two-button front end: synchronise, debounce, then emit one-cycle
// UP/DOWN strobes with hold-to-repeat and conflict suppression.
module button_conditioner #(
   parameter int DEBOUNCE_CYCLES = 1250000,
   parameter int REPEAT_DELAY    = 62500000,
   parameter int REPEAT_PERIOD   = 12500000,
   parameter int CNT_W           = 27
) (
   input  logic CLOCK,
   input  logic RESET,
   input  logic BTN0,
   input  logic BTN1,
   output logic UP_PULSE,
   output logic DOWN_PULSE,
   output logic BTN0_LEVEL,
   output logic BTN1_LEVEL
);

   localparam logic [1:0] ST_IDLE   = 2'd0;
   localparam logic [1:0] ST_WAIT   = 2'd1;
   localparam logic [1:0] ST_REPEAT = 2'd2;

   localparam logic [CNT_W-1:0] DB_LAST =
      CNT_W'(DEBOUNCE_CYCLES - 1);
   localparam logic [CNT_W-1:0] RD_LOAD =
      CNT_W'(REPEAT_DELAY - 1);
   localparam logic [CNT_W-1:0] RP_LOAD =
      CNT_W'(REPEAT_PERIOD - 1);

   logic [1:0]       w_raw;
   logic [1:0]       r_s1;
   logic [1:0]       r_s2;
   logic [1:0]       r_db;
   logic [1:0]       w_db_nxt;
   logic [1:0]       w_fire;
   logic [CNT_W-1:0] r_db_cnt [2];
   logic [1:0]       r_st     [2];
   logic [CNT_W-1:0] r_tmr    [2];
   logic             r_up;
   logic             r_dn;

   assign w_raw = {BTN1, BTN0};

   always_comb begin
      w_db_nxt = r_db;
      w_fire   = '0;
      for (int i = 0; i < 2; i++) begin
         if ((r_s2[i] != r_db[i]) && (r_db_cnt[i] >= DB_LAST))
            w_db_nxt[i] = ~r_db[i];
         unique case (r_st[i])
            ST_IDLE:
               w_fire[i] = r_db[i];
            ST_WAIT, ST_REPEAT:
               w_fire[i] = r_db[i] && (r_tmr[i] == '0);
            default:
               w_fire[i] = 1'b0;
         endcase
      end
   end

   always_ff @(posedge CLOCK or negedge RESET) begin
      if (!RESET) begin
         r_s1 <= '0;
         r_s2 <= '0;
         r_db <= '0;
         for (int i = 0; i < 2; i++)
            r_db_cnt[i] <= '0;
      end else begin
         r_s1 <= w_raw;
         r_s2 <= r_s1;
         r_db <= w_db_nxt;
         for (int i = 0; i < 2; i++) begin
            if (r_s2[i] == r_db[i])
               r_db_cnt[i] <= '0;
            else if (r_db_cnt[i] >= DB_LAST)
               r_db_cnt[i] <= '0;
            else
               r_db_cnt[i] <= r_db_cnt[i] + 1'b1;
         end
      end
   end

   // Timers only count down from a nonzero value, so they never wrap.
   always_ff @(posedge CLOCK or negedge RESET) begin
      if (!RESET) begin
         r_up <= 1'b0;
         r_dn <= 1'b0;
         for (int i = 0; i < 2; i++) begin
            r_st[i]  <= ST_IDLE;
            r_tmr[i] <= '0;
         end
      end else begin
         for (int i = 0; i < 2; i++) begin
            unique case (r_st[i])
               ST_IDLE: begin
                  if (r_db[i]) begin
                     r_st[i]  <= ST_WAIT;
                     r_tmr[i] <= RD_LOAD;
                  end
               end
               ST_WAIT, ST_REPEAT: begin
                  if (!r_db[i]) begin
                     r_st[i]  <= ST_IDLE;
                     r_tmr[i] <= '0;
                  end else if (r_tmr[i] == '0) begin
                     r_st[i]  <= ST_REPEAT;
                     r_tmr[i] <= RP_LOAD;
                  end else begin
                     r_tmr[i] <= r_tmr[i] - 1'b1;
                  end
               end
               default: begin
                  r_st[i]  <= ST_IDLE;
                  r_tmr[i] <= '0;
               end
            endcase
         end
         // A strobe shows only while its own level is 1 and the other is 0.
         r_up <= w_fire[0] & w_db_nxt[0] & ~w_db_nxt[1];
         r_dn <= w_fire[1] & w_db_nxt[1] & ~w_db_nxt[0];
      end
   end

   assign UP_PULSE   = r_up;
   assign DOWN_PULSE = r_dn;
   assign BTN0_LEVEL = r_db[0];
   assign BTN1_LEVEL = r_db[1];

endmodule

// File: tb/tb_button_conditioner.sv
// Randomised and directed stimulus for button_conditioner, checked
// each cycle against a window/age based reference model.
module tb_button_conditioner;

   localparam int D  = 4;
   localparam int RD = 10;
   localparam int RP = 3;

   logic clk;
   logic rst_n;
   logic b0;
   logic b1;
   logic up;
   logic dn;
   logic l0;
   logic l1;

   int total = 0;
   int bad   = 0;

   logic [3:0] exp_q [$];

   button_conditioner #(
      .DEBOUNCE_CYCLES(D),
      .REPEAT_DELAY(RD),
      .REPEAT_PERIOD(RP),
      .CNT_W(27)
   ) dut (
      .CLOCK(clk),
      .RESET(rst_n),
      .BTN0(b0),
      .BTN1(b1),
      .UP_PULSE(up),
      .DOWN_PULSE(dn),
      .BTN0_LEVEL(l0),
      .BTN1_LEVEL(l1)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Reference model: raw samples history, debounced level changes when
   // the last D synchronised samples all differ, pulses by hold age.
   bit m_hist [2][D+2];
   bit m_db   [2];
   bit m_act  [2];
   int m_age  [2];
   bit m_fire [2];
   bit m_prev;
   bit m_diff;
   bit m_up;
   bit m_dn;

   always @(posedge clk) begin
      if (!rst_n) begin
         for (int b = 0; b < 2; b++) begin
            for (int j = 0; j < D + 2; j++) m_hist[b][j] = 1'b0;
            m_db[b]  = 1'b0;
            m_act[b] = 1'b0;
            m_age[b] = 0;
         end
         exp_q.push_back(4'b0000);
      end else begin
         for (int b = 0; b < 2; b++) begin
            for (int j = D + 1; j > 0; j--) m_hist[b][j] = m_hist[b][j-1];
            m_hist[b][0] = (b == 0) ? b0 : b1;
            m_diff = 1'b1;
            for (int j = 2; j < D + 2; j++)
               if (m_hist[b][j] == m_db[b]) m_diff = 1'b0;
            m_prev = m_db[b];
            if (m_diff) m_db[b] = ~m_db[b];
            m_fire[b] = 1'b0;
            if (m_prev) begin
               if (!m_act[b]) begin
                  m_act[b]  = 1'b1;
                  m_age[b]  = 0;
                  m_fire[b] = 1'b1;
               end else begin
                  m_age[b]++;
                  if (m_age[b] == RD ||
                      (m_age[b] > RD && (m_age[b] - RD) % RP == 0))
                     m_fire[b] = 1'b1;
               end
            end else begin
               m_act[b] = 1'b0;
            end
         end
         m_up = m_fire[0] & m_db[0] & ~m_db[1];
         m_dn = m_fire[1] & m_db[1] & ~m_db[0];
         exp_q.push_back({m_up, m_dn, m_db[0], m_db[1]});
      end
   end

   // Monitor: pops one expectation per edge, samples 2 time units later.
   logic [3:0] exp_v;
   always begin
      @(posedge clk);
      #2;
      total++;
      if (exp_q.size() == 0) begin
         bad++;
         $display("FAIL scoreboard_empty t=%0t", $time);
      end else begin
         exp_v = exp_q.pop_front();
         if ({up, dn, l0, l1} !== exp_v) begin
            bad++;
            $display("FAIL outputs t=%0t got up=%b dn=%b l0=%b l1=%b want up=%b dn=%b l0=%b l1=%b",
                     $time, up, dn, l0, l1,
                     exp_v[3], exp_v[2], exp_v[1], exp_v[0]);
         end
      end
      total++;
      if ((up & dn) !== 1'b0) begin
         bad++;
         $display("FAIL mutex t=%0t got up=%b dn=%b want not both",
                  $time, up, dn);
      end
   end

   task automatic hold(input bit v0, input bit v1, input int n);
      b0 = v0;
      b1 = v1;
      repeat (n) begin
         @(posedge clk);
         #3;
      end
   endtask

   task automatic reset_pulse(input int n);
      rst_n = 1'b0;
      #1;
      total++;
      if ({up, dn, l0, l1} !== 4'b0000) begin
         bad++;
         $display("FAIL async_reset t=%0t got up=%b dn=%b l0=%b l1=%b want 0000",
                  $time, up, dn, l0, l1);
      end
      repeat (n) begin
         @(posedge clk);
         #3;
      end
      rst_n = 1'b1;
   endtask

   initial begin
      rst_n = 1'b0;
      b0    = 1'b0;
      b1    = 1'b0;
      @(posedge clk);
      #3;
      reset_pulse(2);
      hold(0, 0, 3);
      // clean press and long hold
      hold(1, 0, 30);
      hold(0, 0, 15);
      // bounce on the down button, then steady
      for (int k = 0; k < 3; k++) begin
         hold(0, 1, 1);
         hold(0, 0, 1);
      end
      hold(0, 1, 12);
      hold(0, 0, 12);
      // short glitch
      hold(1, 0, 3);
      hold(0, 0, 10);
      // overlap of both buttons
      hold(1, 0, 11);
      hold(1, 1, 15);
      hold(1, 0, 15);
      hold(0, 0, 12);
      // reset in the middle of a hold
      hold(1, 0, 14);
      reset_pulse(2);
      hold(1, 0, 20);
      hold(0, 0, 12);
      // release while repeating, then re-press
      hold(1, 0, 20);
      hold(0, 0, 12);
      hold(1, 0, 12);
      hold(0, 0, 12);
      // random segments
      for (int k = 0; k < 150; k++) begin
         if ($urandom_range(0, 29) == 0)
            reset_pulse($urandom_range(1, 3));
         hold(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
              $urandom_range(1, 16));
      end
      hold(0, 0, 12);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/button_conditioner.md
Name: button_conditioner

Overview:
- Upstream front end for the LED up/down counter. Conditions the two raw push-buttons: synchronizes them, debounces them, then emits single-cycle UP/DOWN step pulses with hold-to-repeat.
- The counter consumes only clean one-cycle pulses and needs no clock-divided domain of its own.
- Everything runs on the single system clock.

Parameters:
- DEBOUNCE_CYCLES, 1250000, consecutive stable samples needed to accept a level change (10 ms at 125 MHz).
- REPEAT_DELAY, 62500000, cycles from the first pulse to the first auto-repeat pulse (0.5 s).
- REPEAT_PERIOD, 12500000, cycles between later auto-repeat pulses (0.1 s).
- CNT_W, 27, width of the internal timers; must hold max(DEBOUNCE_CYCLES, REPEAT_DELAY, REPEAT_PERIOD).

Ports:
- CLOCK  input  1  system clock, 125 MHz.
- RESET  input  1  asynchronous, active-low reset. Asserts immediately when low; deasserts synchronously to CLOCK.
- BTN0  input  1  raw up button, asynchronous, active-high, bouncy.
- BTN1  input  1  raw down button, asynchronous, active-high, bouncy.
- UP_PULSE  output  1  one-cycle count-up strobe.
- DOWN_PULSE  output  1  one-cycle count-down strobe.
- BTN0_LEVEL  output  1  debounced BTN0 level.
- BTN1_LEVEL  output  1  debounced BTN1 level.

Behaviour:
- Reset (RESET low): all sync flops, debounced levels, timers and FSMs clear. All four outputs read 0 asynchronously. Outputs hold 0 until the first valid detection after release.
- Synchronizer: a 2-flop chain per button. Only its second stage, btn_s, feeds downstream logic.
- Debounce, per button:
  - Counter db_cnt and level db.
  - If btn_s == db, db_cnt clears to 0.
  - If btn_s != db, db_cnt increments. When it would reach DEBOUNCE_CYCLES, db toggles and db_cnt clears.
  - Any sample equal to db before that point restarts the count.
  - Result: a glitch shorter than DEBOUNCE_CYCLES samples never changes db.
- Repeat FSM, per button, all outputs registered:
  - IDLE: when db rises, emit a pulse next edge, load timer = REPEAT_DELAY-1, go to WAIT.
  - WAIT: timer decrements each cycle. If db falls, go to IDLE with no pulse. At timer==0, emit a pulse, load REPEAT_PERIOD-1, go to REPEAT.
  - REPEAT: same as WAIT, but reload REPEAT_PERIOD-1 after each pulse. If db falls, go to IDLE.
  - A release never produces a pulse.
- Latency: raw stable high, first clean sample at edge 1. Then btn_s=1 at edge 2, db=1 at edge 2+DEBOUNCE_CYCLES, pulse high for exactly the one cycle after edge 3+DEBOUNCE_CYCLES.
- Pulse spacing:
  - First to second pulse: exactly REPEAT_DELAY cycles.
  - Thereafter: exactly REPEAT_PERIOD cycles.
- Conflict: while BTN0_LEVEL and BTN1_LEVEL are both 1, UP_PULSE and DOWN_PULSE are forced to 0.
  - Both FSMs and timers keep running, so pulses scheduled inside the conflict window are dropped, not deferred.
  - When one button is released, the survivor resumes on its existing timer phase.
- Mutual exclusion: UP_PULSE and DOWN_PULSE are never high in the same cycle.
- Level outputs: BTN*_LEVEL equal db directly, with no extra delay.
- Reset mid-hold: outputs drop to 0 immediately. After release, a still-held button is treated as a new press. The first pulse follows the standard latency from the first post-reset edge.
- Timers saturate safely: no wrap can produce a spurious pulse.

Test Plan (bench parameters DEBOUNCE_CYCLES=4, REPEAT_DELAY=10, REPEAT_PERIOD=3; edges counted from the first edge sampling BTN0=1):
- Clean press, hold BTN0 for 30 cycles:
  - BTN0_LEVEL rises after edge 6.
  - UP_PULSE high one cycle after edges 7, 17, 20, 23, 26, 29.
  - DOWN_PULSE stays 0 throughout.
- Bounce 1,0,1,0,1,0 per cycle on BTN1, then steady 1:
  - No DOWN_PULSE during the bounce.
  - Single DOWN_PULSE 7 edges after the steady 1 begins.
- 3-cycle glitch on BTN0 then 0: BTN0_LEVEL stays 0 and UP_PULSE stays 0 for the whole run.
- Hold BTN0, then at edge 12 also hold BTN1 for 15 cycles, then release BTN1:
  - UP_PULSE at edge 7.
  - No pulses while both levels are 1.
  - UP_PULSE resumes on the original 3-cycle phase after BTN1_LEVEL falls.
  - Never both pulses in the same cycle.
- Hold BTN0, assert RESET low at edge 15 for 2 cycles, keep BTN0 high:
  - All outputs 0 asynchronously during reset.
  - Next UP_PULSE 7 edges after the first post-reset edge.
- Release while in REPEAT (BTN0 low from edge 21):
  - No pulse on release.
  - BTN0_LEVEL falls 6 edges after the release.
  - FSM returns to IDLE and a re-press repeats the 7-edge latency.
